// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// usb_pkg
// ----------------------------------------------------------------------------
// Shared USB transmit types: PID encodings, transmitter FSM states, line
// symbols, the SYNC byte and the PID-byte helper.
// Revision: 1.0 - initial release
// ============================================================================
package usb_pkg;

  typedef enum logic [3:0] {
    OUT   = 4'b0001,
    IN    = 4'b1001,
    DATA0 = 4'b0011,
    ACK   = 4'b0010,
    NAK   = 4'b1010
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_PID     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } tx_state_t;

  // What the line driver should present in the next cycle.
  typedef enum logic [1:0] {
    SYM_IDLE = 2'd0,
    SYM_BIT  = 2'd1,
    SYM_SE0  = 2'd2,
    SYM_J    = 2'd3
  } line_sym_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // PID byte on the wire: check nibble in the upper half.
  function automatic logic [7:0] pid_byte(input pid_t pid);
    return {~pid, pid};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpdm_encode_if.sv
`default_nettype none
// ============================================================================
// dpdm_encode_if
// ----------------------------------------------------------------------------
// Packet request and payload stream between the upstream TX stages and the
// DP/DM encoder.
//   master : pkt_start, pkt_pid, pkt_has_payload, pay_valid, pay_bit,
//            pay_last out; pay_ready in
//   slave  : the mirror image (encoder side)
// Revision: 1.0 - initial release
// ============================================================================
interface dpdm_encode_if;
  import usb_pkg::*;

  logic pkt_start;
  pid_t pkt_pid;
  logic pkt_has_payload;
  logic pay_valid;
  logic pay_bit;
  logic pay_last;
  logic pay_ready;

  modport master (
    output pkt_start, pkt_pid, pkt_has_payload, pay_valid, pay_bit, pay_last,
    input  pay_ready
  );

  modport slave (
    input  pkt_start, pkt_pid, pkt_has_payload, pay_valid, pay_bit, pay_last,
    output pay_ready
  );
endinterface
`default_nettype wire

// File: rtl/PISO_Register_Right.sv
`default_nettype none
// ============================================================================
// PISO_Register_Right
// ----------------------------------------------------------------------------
// Parallel-load, right-shift register. o_bit is the LSB being sent this
// cycle; on a load cycle that is the LSB of i_data itself, so a freshly
// loaded byte starts streaming without a bubble.
//   clock, reset : clock and synchronous active-high reset
//   i_load       : load i_data (bit 0 goes out now, rest stored)
//   i_shift      : shift stored bits right by one
//   i_data       : parallel word
//   o_bit        : serial bit for this cycle
// Revision: 1.0 - initial release
// ============================================================================
module PISO_Register_Right #(
  parameter int WIDTH = 8
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic             i_shift,
  input  wire logic [WIDTH-1:0] i_data,
  output logic                  o_bit
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= {1'b0, i_data[WIDTH-1:1]};
    end else if (i_shift) begin
      r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign o_bit = i_load ? i_data[0] : r_q[0];
endmodule
`default_nettype wire

// File: rtl/dpdm_encode.sv
`default_nettype none
// ============================================================================
// dpdm_encode
// ----------------------------------------------------------------------------
// USB low-level packet transmitter: SYNC, PID byte, optional streamed payload
// and EOP on DP/DM, then bus release.
//   clock, reset   : clock (one wire bit per cycle), sync active-high reset
//   tx_if          : packet request + payload valid/ready stream (slave)
//   DP_out, DM_out : registered line values
//   dpdm_en        : registered drive enable (0 = tri-state)
//   host_sending   : = dpdm_en, blanks the local receiver
//   tx_busy        : accept through last J cycle
//   tx_done        : pulse in the first cycle after dpdm_en falls
//   tx_error       : pulse with tx_done when the payload underran
// Revision: 1.0 - initial release
// ============================================================================
module dpdm_encode
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN   = SYNC_BYTE,
  parameter int         EOP_SE0_CYCLES = 2,
  parameter int         EOP_J_CYCLES   = 1
) (
  input  wire logic       clock,
  input  wire logic       reset,
  dpdm_encode_if.slave    tx_if,
  output logic            DP_out,
  output logic            DM_out,
  output logic            dpdm_en,
  output logic            host_sending,
  output logic            tx_busy,
  output logic            tx_done,
  output logic            tx_error
);
  // The FSM selects a symbol in cycle t and the line shows it in t+1. The
  // accept cycle already selects SYNC bit 0, so the SYNC state itself only
  // needs the remaining 7 bits.
  tx_state_t   r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  pid_t        r_pid;
  logic        r_has_pay, r_err;
  logic        r_dp, r_dm, r_en, r_done, r_error;
  line_sym_t   w_sym;
  logic        w_load, w_shift, w_accept, w_underrun, w_done;
  logic        w_piso_bit, w_tx_bit;
  logic [7:0]  w_load_data;

  PISO_Register_Right #(.WIDTH(8)) u_piso (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_bit   (w_piso_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 4'd1;
    w_sym       = SYM_IDLE;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_data = SYNC_PATTERN;
    w_accept    = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        // r_en still high means the last J is on the wire: still busy.
        if (tx_if.pkt_start && !r_en) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_sym       = SYM_BIT;
          w_state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        w_shift = 1'b1;
        w_sym   = SYM_BIT;
        if (r_cnt == 4'd6) begin
          w_state_nxt = ST_PID;
          w_cnt_nxt   = '0;
        end
      end
      ST_PID: begin
        w_load_data = pid_byte(r_pid);
        w_load      = (r_cnt == 4'd0);
        w_shift     = (r_cnt != 4'd0);
        w_sym       = SYM_BIT;
        if (r_cnt == 4'd7) begin
          w_state_nxt = r_has_pay ? ST_PAYLOAD : ST_EOP_SE0;
          w_cnt_nxt   = '0;
        end
      end
      ST_PAYLOAD: begin
        if (tx_if.pay_valid) begin
          w_sym = SYM_BIT;
          if (tx_if.pay_last) begin
            w_state_nxt = ST_EOP_SE0;
            w_cnt_nxt   = '0;
          end
        end else begin
          // The underrun cycle already emits the first SE0, so the EOP
          // stays EOP_SE0_CYCLES long and dpdm_en length stays 16+P+EOP.
          w_underrun = 1'b1;
          w_sym      = SYM_SE0;
          if (EOP_SE0_CYCLES > 1) begin
            w_state_nxt = ST_EOP_SE0;
            w_cnt_nxt   = 4'd1;
          end else begin
            w_state_nxt = ST_EOP_J;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_EOP_SE0: begin
        w_sym = SYM_SE0;
        if (r_cnt == 4'(EOP_SE0_CYCLES - 1)) begin
          w_state_nxt = ST_EOP_J;
          w_cnt_nxt   = '0;
        end
      end
      ST_EOP_J: begin
        w_sym = SYM_J;
        if (r_cnt == 4'(EOP_J_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_tx_bit = (r_state == ST_PAYLOAD) ? tx_if.pay_bit : w_piso_bit;
  // IDLE with the enable still high: the final J is on the wire now.
  assign w_done   = (r_state == ST_IDLE) && r_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dp      <= 1'b0;
      r_dm      <= 1'b0;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err     <= 1'b0;
      r_pid     <= ACK;
      r_has_pay <= 1'b0;
    end else begin
      r_dp    <= (w_sym == SYM_BIT) ? w_tx_bit : (w_sym == SYM_J);
      r_dm    <= (w_sym == SYM_BIT) && !w_tx_bit;
      r_en    <= (w_sym != SYM_IDLE);
      r_done  <= w_done;
      r_error <= w_done && r_err;
      if (w_underrun) begin
        r_err <= 1'b1;
      end else if (w_done) begin
        r_err <= 1'b0;
      end
      if (w_accept) begin
        r_pid     <= tx_if.pkt_pid;
        r_has_pay <= tx_if.pkt_has_payload;
      end
    end
  end

  assign tx_if.pay_ready = (r_state == ST_PAYLOAD);
  assign DP_out          = r_dp;
  assign DM_out          = r_dm;
  assign dpdm_en         = r_en;
  assign host_sending    = r_en;
  // The enable covers exactly accept+1 through the last J cycle.
  assign tx_busy         = r_en;
  assign tx_done         = r_done;
  assign tx_error        = r_error;
endmodule
`default_nettype wire

// File: doc/dpdm_encode.md
Name: dpdm_encode

Overview:
USB low-level packet transmitter, the transmit-side counterpart of the DP/DM decoder. On request it serializes SYNC, the PID byte, an optional streamed payload and an EOP onto the DP/DM pair. It then releases the bus. Upstream stages (CRC, bit-stuff, NRZI) feed payload bits through a valid/ready stream. The block's host_sending output gates the local decoder so the host does not receive its own packets.

Parameters:
SYNC_PATTERN, 8'h80, SYNC byte sent LSB first (seven 0s, then 1).
EOP_SE0_CYCLES, 2, number of SE0 cycles in the EOP.
EOP_J_CYCLES, 1, number of J (DP=1, DM=0) cycles after the SE0 cycles, before release.

Ports:
clock  in  1  system clock; one wire bit per cycle
reset  in  1  synchronous, active-high reset
pkt_start  in  1  packet request; accepted only in IDLE
pkt_pid  in  4  usb_pkg::pid_t PID nibble; latched on accept
pkt_has_payload  in  1  1 = DATA-type packet with payload; latched on accept
pay_valid  in  1  payload bit valid
pay_bit  in  1  payload bit (already CRC'd/stuffed)
pay_last  in  1  marks the final payload bit
pay_ready  out  1  = (state==PAYLOAD); combinational
DP_out  out  1  registered D+ drive value
DM_out  out  1  registered D- drive value
dpdm_en  out  1  registered drive enable; top level tri-states DP/DM to z when 0
host_sending  out  1  = dpdm_en; gates the receiver
tx_busy  out  1  high from accept through the last J cycle
tx_done  out  1  one-cycle pulse in the first cycle after dpdm_en falls
tx_error  out  1  one-cycle pulse coincident with tx_done when payload underran

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: state=IDLE; DP_out=0, DM_out=0, dpdm_en=0, tx_busy=0, tx_done=0, tx_error=0. This applies mid-packet too: the bus releases at the next edge, no EOP is sent, and tx_done does not pulse.
- Wire mapping: bit 1 -> DP=1, DM=0. Bit 0 -> DP=0, DM=1. SE0 -> DP=0, DM=0. J -> DP=1, DM=0.
- States: IDLE, SYNC, PID, PAYLOAD, EOP_SE0, EOP_J.
- IDLE: pkt_start=1 latches pkt_pid and pkt_has_payload and goes to SYNC. tx_busy rises at the same edge.
- SYNC: 8 cycles, SYNC_PATTERN sent LSB first. Then go to PID.
- PID: 8 cycles, byte {~pid, pid} sent LSB first. Then go to PAYLOAD if has_payload, else EOP_SE0.
- PAYLOAD:
  - Each cycle with pay_valid=1 consumes pay_bit.
  - pay_last=1 on the consumed bit -> EOP_SE0.
  - pay_valid=0 in any PAYLOAD cycle -> underrun. Nothing is consumed, error flag is set, and the FSM goes to EOP_SE0 (truncated packet).
- EOP_SE0: EOP_SE0_CYCLES cycles, then EOP_J.
- EOP_J: EOP_J_CYCLES cycles, then IDLE.
- IDLE output: dpdm_en=0. tx_done pulses; tx_error pulses too if the flag is set, then the flag clears.
- Latency: a bit consumed or selected in cycle t is driven on DP/DM in cycle t+1. First SYNC bit appears in the cycle after pkt_start is accepted.
- dpdm_en stays high for exactly 16 + P + EOP_SE0_CYCLES + EOP_J_CYCLES consecutive cycles, where P = payload bits consumed.
- pkt_start while tx_busy=1: ignored, no queueing.
- Back-to-back: pkt_start in the tx_done cycle is accepted. The bus is therefore idle (dpdm_en=0) for exactly one cycle.
- pkt_pid is transmitted verbatim (no legality check).
- Counter: 4-bit bit/cycle counter, reset on every state change; it must cover max(8, EOP_SE0_CYCLES, EOP_J_CYCLES).

Decomposition:
- usb_pkg holds:
  - pid_t enum: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, ACK=4'b0010, NAK=4'b1010.
  - tx_state_t.
  - SYNC_BYTE constant.
  - Function pid_byte(pid_t) returning {~pid, pid}.
- One sub-module: PISO_Register_Right, an 8-bit parallel-load, right-shift register. It is loaded with SYNC then the PID byte, and shifts out the LSB each cycle.

Test Plan:
- ACK handshake, no payload: pkt_start, pid=ACK -> wire bits 0000000 1, 0 1 0 0 1 0 1 1, then SE0, SE0, J. dpdm_en high for 19 cycles, then tx_done=1, tx_error=0.
- DATA0 with 16 payload bits 16'hA5C3, streamed LSB first with pay_valid constantly 1 and pay_last on bit 16 -> SYNC, byte 8'hC3 LSB first, the 16 bits in order, EOP. dpdm_en high for 35 cycles, pay_ready high for exactly 16 cycles.
- Underrun: DATA0, pay_valid dropped after 5 bits -> 5 payload bits on the wire, then SE0, SE0, J. tx_done and tx_error pulse together.
- pkt_start pulsed at cycle 3 of PID state during an ACK send -> ignored; exactly one packet emitted; tx_busy is never re-armed mid-packet.
- reset asserted during PAYLOAD -> next cycle dpdm_en=0, DP_out=DM_out=0, tx_busy=0, no tx_done. A fresh pkt_start after reset sends a full correct packet.
- Back-to-back NAK then OUT, with the second pkt_start in the tx_done cycle -> exactly one idle cycle between packets. Second PID byte = 8'hE1 on the wire LSB first.
